cpu_sequencer: RTL

Multi-cycle fetch/decode/execute controller for the 8-bit, 4-register CPU datapath. Fetches each two-byte instruction from instruction memory over a req/ack handshake and decodes the 4-bit opcode. Drives ALU select, register-file selects and write-back for the datapath. Sequences branches (with a hardware return stack), LOAD/STORE handshakes and IN/OUT port handshakes.

---
 rtl/cpu_sequencer_if.sv | 38 +++
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Bundle of the sequencer's fetch, datapath-control, data-memory and I/O port signals.
// Purely structural: no storage, no latency of its own.
// Backpressure is carried by the req/ack and valid/ready pairs contained here.
interface cpu_sequencer_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [3:0] alu_sel;
    logic [1:0] ra_sel;
    logic [1:0] rb_sel;
    logic [7:0] imm;
    logic       reg_wb;
    logic [1:0] wb_src;
    logic       z_flag;
    logic       n_flag;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       out_valid;
    logic       out_ready;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pc;
    logic       fault;

    modport master (
        output imem_req, imem_addr, alu_sel, ra_sel, rb_sel, imm, reg_wb, wb_src,
               dmem_req, dmem_we, out_valid, in_ready, pc, fault,
        input  imem_ack, imem_data, z_flag, n_flag, dmem_ack, out_ready, in_valid
    );

    modport slave (
        input  imem_req, imem_addr, alu_sel, ra_sel, rb_sel, imm, reg_wb, wb_src,
               dmem_req, dmem_we, out_valid, in_ready, pc, fault,
        output imem_ack, imem_data, z_flag, n_flag, dmem_ack, out_ready, in_valid
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit 4-register CPU, with a hardware return stack.
// Latency: 3 cycles per ALU/NOP/branch/LOADIMM instruction, 4 for LOAD/STORE/IN/OUT with zero-wait acks.
// Backpressure: each fetch, memory and port phase holds its req/valid/ready until the partner acks.
module cpu_sequencer #(
    parameter int         RS_DEPTH = 4,
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_sequencer_if.master  bus
);

    localparam int SPW = $clog2(RS_DEPTH);

    localparam logic [2:0] S_FETCH_HI = 3'd0;
    localparam logic [2:0] S_FETCH_LO = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_OUT_WAIT = 3'd4;
    localparam logic [2:0] S_IN_WAIT  = 3'd5;
    localparam logic [2:0] S_FAULT    = 3'd6;

    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h7;
    localparam logic [3:0] OP_MOV   = 4'h8;
    localparam logic [3:0] OP_BR    = 4'h9;
    localparam logic [3:0] OP_BRC   = 4'hA;
    localparam logic [3:0] OP_CALL  = 4'hB;
    localparam logic [3:0] OP_RET   = 4'hC;
    localparam logic [3:0] OP_LOAD  = 4'hD;
    localparam logic [3:0] OP_STORE = 4'hE;
    localparam logic [3:0] OP_LDI   = 4'hF;

    logic [2:0]   state;
    logic [7:0]   pc_q;
    logic [7:0]   ir_hi;
    logic [7:0]   ir_lo;
    logic [SPW:0] sp;
    logic         fault_q;
    logic [7:0]   rs_mem [RS_DEPTH];

    logic [3:0]   op;
    logic         is_alu;
    logic         stack_full;
    logic         stack_empty;
    logic [SPW:0] sp_m1;
    logic         br_taken;

    assign op          = ir_hi[7:4];
    assign is_alu      = ((op >= 4'd1) && (op <= 4'd5)) || (op == OP_MOV);
    assign stack_full  = (sp == (SPW+1)'(RS_DEPTH));
    assign stack_empty = (sp == '0);
    assign sp_m1       = sp - (SPW+1)'(1);
    // ir_hi[0] picks the flag for conditional branches: 0 = zero, 1 = negative.
    assign br_taken    = ir_hi[0] ? bus.n_flag : bus.z_flag;

    // Sequencer state, program counter, instruction register, stack pointer and sticky fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH_HI;
            pc_q    <= PC_RESET;
            ir_hi   <= 8'h00;
            ir_lo   <= 8'h00;
            sp      <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH_HI: if (bus.imem_ack) begin
                    ir_hi <= bus.imem_data;
                    state <= S_FETCH_LO;
                end
                S_FETCH_LO: if (bus.imem_ack) begin
                    ir_lo <= bus.imem_data;
                    pc_q  <= pc_q + 8'd2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH_HI;
                    case (op)
                        OP_OUT:   state <= S_OUT_WAIT;
                        OP_IN:    state <= S_IN_WAIT;
                        OP_BR:    pc_q  <= ir_lo;
                        OP_BRC:   if (br_taken) pc_q <= ir_lo;
                        OP_CALL: begin
                            if (stack_full) begin
                                fault_q <= 1'b1;
                                state   <= S_FAULT;
                            end else begin
                                sp   <= sp + (SPW+1)'(1);
                                pc_q <= ir_lo;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                fault_q <= 1'b1;
                                state   <= S_FAULT;
                            end else begin
                                sp   <= sp_m1;
                                pc_q <= rs_mem[sp_m1[SPW-1:0]];
                            end
                        end
                        OP_LOAD, OP_STORE: state <= S_MEM_WAIT;
                        default: ;
                    endcase
                end
                S_MEM_WAIT: if (bus.dmem_ack)  state <= S_FETCH_HI;
                S_OUT_WAIT: if (bus.out_ready) state <= S_FETCH_HI;
                S_IN_WAIT:  if (bus.in_valid)  state <= S_FETCH_HI;
                S_FAULT:    state <= S_FAULT;
                default:    state <= S_FETCH_HI;
            endcase
        end
    end

    // Return-stack storage: written only on a non-overflowing BR.SUB, contents need no reset.
    always_ff @(posedge clk) begin
        if (state == S_EXEC && op == OP_CALL && !stack_full)
            rs_mem[sp[SPW-1:0]] <= pc_q;
    end

    // Fetch request is masked while reset is held so nothing is issued before release.
    assign bus.imem_req  = rst_n && (state == S_FETCH_HI || state == S_FETCH_LO);
    assign bus.imem_addr = (state == S_FETCH_LO) ? pc_q + 8'd1 : pc_q;

    assign bus.alu_sel   = (state == S_EXEC && is_alu) ? op : 4'd0;
    assign bus.ra_sel    = ir_hi[3:2];
    assign bus.rb_sel    = ir_hi[1:0];
    assign bus.imm       = ir_lo;

    assign bus.reg_wb    = (state == S_EXEC && (is_alu || op == OP_LDI))
                        || (state == S_MEM_WAIT && op == OP_LOAD && bus.dmem_ack)
                        || (state == S_IN_WAIT && bus.in_valid);

    assign bus.wb_src    = (state == S_EXEC && op == OP_LDI)      ? 2'd3 :
                           (state == S_MEM_WAIT && op == OP_LOAD) ? 2'd2 :
                           (state == S_IN_WAIT)                   ? 2'd1 : 2'd0;

    assign bus.dmem_req  = (state == S_MEM_WAIT);
    assign bus.dmem_we   = (state == S_MEM_WAIT) && (op == OP_STORE);
    assign bus.out_valid = (state == S_OUT_WAIT);
    assign bus.in_ready  = (state == S_IN_WAIT);
    assign bus.pc        = pc_q;
    assign bus.fault     = fault_q;

endmodule
